// File: rtl/prog_loader.sv
// Byte-stream program loader: packs received bytes into 16-bit words, writes them to program memory
// from address 0 and holds the CPU in reset until a HALT word lands. Optional checksum: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int B = 16,
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         pm_wr_en,
  output logic [W-1:0] pm_addr,
  output logic [B-1:0] pm_data,
  output logic         cpu_reset,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   addr_q, addr_d;
  logic [7:0]     hi_q, hi_d;
  logic           wr_q, wr_d;
  logic [W-1:0]   paddr_q, paddr_d;
  logic [B-1:0]   pdata_q, pdata_d;
  logic [B-1:0]   word;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]     xor_q, xor_d;
`endif

  assign word = {hi_q, rx_data};

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d = state_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    wr_d    = 1'b0;
    paddr_d = paddr_q;
    pdata_d = pdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        // A byte coinciding with an accepted start is deliberately dropped.
        if (start) begin
          state_d = S_HI;
          addr_d  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          xor_d   = 8'h00;
`endif
        end
      end
      S_HI: begin
        if (rx_valid) begin
          hi_d    = rx_data;
          state_d = S_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
          xor_d   = xor_q ^ rx_data;
`endif
        end
      end
      S_LO: begin
        if (rx_valid) begin
          wr_d    = 1'b1;
          paddr_d = addr_q;
          pdata_d = word;
`ifdef PROG_LOADER_CHECKSUM_EN
          xor_d   = xor_q ^ rx_data;
`endif
          if (word[15:11] == 5'b00000) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else if (addr_q == {W{1'b1}}) begin
            // Overflow: the last word is still written, but the load fails.
            state_d = S_ERR;
          end else begin
            addr_d  = addr_q + W'(1);
            state_d = S_HI;
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (rx_valid) begin
          state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      hi_q    <= 8'h00;
      wr_q    <= 1'b0;
      paddr_q <= '0;
      pdata_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      wr_q    <= wr_d;
      paddr_q <= paddr_d;
      pdata_q <= pdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign pm_wr_en  = wr_q;
  assign pm_addr   = paddr_q;
  assign pm_data   = pdata_q;
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign cpu_reset = (state_q != S_DONE);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a default-width instance plus a W=2 instance for the overflow case.
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic        wr, cpu_rst, busy, done, err;
  logic [10:0] addr;
  logic [15:0] data;

  logic        s_wr, s_cpu_rst, s_busy, s_done, s_err;
  logic [1:0]  s_addr;
  logic [15:0] s_data;

  int checks = 0;
  int errors = 0;

  prog_loader #(.B(16), .W(11)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .pm_wr_en(wr), .pm_addr(addr), .pm_data(data), .cpu_reset(cpu_rst),
    .busy(busy), .done(done), .err(err)
  );

  prog_loader #(.B(16), .W(2)) dut_s (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .pm_wr_en(s_wr), .pm_addr(s_addr), .pm_data(s_data), .cpu_reset(s_cpu_rst),
    .busy(s_busy), .done(s_done), .err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wr"},   {31'd0, wr},      32'd0);
    check({tag, "_addr"}, {21'd0, addr},    32'd0);
    check({tag, "_data"}, {16'd0, data},    32'd0);
    check({tag, "_crst"}, {31'd0, cpu_rst}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy},    32'd0);
    check({tag, "_done"}, {31'd0, done},    32'd0);
    check({tag, "_err"},  {31'd0, err},     32'd0);
  endtask

  // Word with three idle cycles after each byte; pm_wr_en must be a single-cycle pulse.
  task automatic send_word_gap(input logic [7:0] hi, input logic [7:0] lo,
                               input logic [10:0] exp_addr, input string tag);
    send(hi);
    repeat (3) tick();
    send(lo);
    check({tag, "_wr"},   {31'd0, wr},   32'd1);
    check({tag, "_addr"}, {21'd0, addr}, {21'd0, exp_addr});
    check({tag, "_data"}, {16'd0, data}, {16'd0, hi, lo});
    tick();
    check({tag, "_wr_off"}, {31'd0, wr}, 32'd0);
    repeat (2) tick();
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Reset and idle
    #2 reset = 1'b0;
    #2;
    check_reset_vals("rst");
    tick();
    reset = 1'b1;
    send(8'h18);
    send(8'h10);
    check_reset_vals("idle_rx");

    // Basic back-to-back load
    do_start();
    check("basic_busy", {31'd0, busy}, 32'd1);
    check("basic_crst", {31'd0, cpu_rst}, 32'd1);
    send(8'h18);
    check("basic_hi_nowr", {31'd0, wr}, 32'd0);
    send(8'h10);
    check("basic_w0_wr", {31'd0, wr}, 32'd1);
    check("basic_w0_addr", {21'd0, addr}, 32'd0);
    check("basic_w0_data", {16'd0, data}, 32'h1810);
    send(8'h08);
    check("basic_hold_wr", {31'd0, wr}, 32'd0);
    check("basic_hold_data", {16'd0, data}, 32'h1810);
    send(8'h01);
    check("basic_w1_addr", {21'd0, addr}, 32'd1);
    check("basic_w1_data", {16'd0, data}, 32'h0801);
    send(8'h00);
    send(8'h00);
    check("basic_w2_wr", {31'd0, wr}, 32'd1);
    check("basic_w2_addr", {21'd0, addr}, 32'd2);
    check("basic_w2_data", {16'd0, data}, 32'h0000);
`ifdef PROG_LOADER_CHECKSUM_EN
    check("basic_chk_wait", {31'd0, done}, 32'd0);
    send(8'h01);
`endif
    check("basic_done", {31'd0, done}, 32'd1);
    check("basic_crst_low", {31'd0, cpu_rst}, 32'd0);
    check("basic_busy_low", {31'd0, busy}, 32'd0);
    check("basic_err", {31'd0, err}, 32'd0);
    tick();
    check("basic_wr_pulse", {31'd0, wr}, 32'd0);
    check("basic_done_sticky", {31'd0, done}, 32'd1);

    // Gapped load; the byte arriving with start is dropped
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    tick();
    start    = 1'b0;
    rx_valid = 1'b0;
    check("gap_done_clr", {31'd0, done}, 32'd0);
    check("gap_busy", {31'd0, busy}, 32'd1);
    check("gap_crst", {31'd0, cpu_rst}, 32'd1);
    send_word_gap(8'h18, 8'h10, 11'd0, "gap_w0");
    send_word_gap(8'h08, 8'h01, 11'd1, "gap_w1");
    send_word_gap(8'h00, 8'h00, 11'd2, "gap_w2");
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h01);
`endif
    check("gap_done", {31'd0, done}, 32'd1);
    check("gap_crst_low", {31'd0, cpu_rst}, 32'd0);

    // Mid-load asynchronous reset
    do_start();
    send(8'h18);
    send(8'h10);
    send(8'h08);
    #2 reset = 1'b0;
    #1;
    check_reset_vals("midrst");
    tick();
    reset = 1'b1;
    do_start();
    send(8'h18);
    send(8'h10);
    check("reload_w0_addr", {21'd0, addr}, 32'd0);
    check("reload_w0_data", {16'd0, data}, 32'h1810);
    send(8'h08);
    send(8'h01);
    check("reload_w1_addr", {21'd0, addr}, 32'd1);
    send(8'h00);
    send(8'h00);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h01);
`endif
    check("reload_done", {31'd0, done}, 32'd1);

    // Overflow on the W=2 instance
    do_start();
    for (int i = 0; i < 4; i++) begin
      check("ovf_busy_before", {31'd0, s_busy}, 32'd1);
      send(8'h08);
      send(8'h01);
      check("ovf_wr", {31'd0, s_wr}, 32'd1);
      check("ovf_addr", {30'd0, s_addr}, i);
      check("ovf_data", {16'd0, s_data}, 32'h0801);
    end
    check("ovf_err", {31'd0, s_err}, 32'd1);
    check("ovf_crst", {31'd0, s_cpu_rst}, 32'd1);
    check("ovf_busy", {31'd0, s_busy}, 32'd0);
    check("ovf_done", {31'd0, s_done}, 32'd0);
    check("wide_no_err", {31'd0, err}, 32'd0);
    tick();
    check("ovf_err_sticky", {31'd0, s_err}, 32'd1);
    do_start();
    check("restart_err_clr", {31'd0, s_err}, 32'd0);
    check("restart_busy", {31'd0, s_busy}, 32'd1);
    check("wide_start_ignored", {31'd0, busy}, 32'd1);
    send(8'h08);
    send(8'h01);
    check("restart_small_addr", {30'd0, s_addr}, 32'd0);
    check("wide_continues_addr", {21'd0, addr}, 32'd4);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Bad checksum
    #2 reset = 1'b0;
    tick();
    reset = 1'b1;
    do_start();
    send(8'h18);
    send(8'h10);
    send(8'h08);
    send(8'h01);
    send(8'h00);
    send(8'h00);
    send(8'h02);
    check("bad_chk_err", {31'd0, err}, 32'd1);
    check("bad_chk_crst", {31'd0, cpu_rst}, 32'd1);
    check("bad_chk_done", {31'd0, done}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader for the accumulator CPU. It collects instruction bytes from a serial receiver, packs them into 16-bit instruction words and writes them into program memory at consecutive addresses starting at 0. The CPU control unit is held in reset for the whole load and released once a HALT word has been stored. It sits between the UART receiver and the program-memory write port, on the writer side of the memory the control unit fetches from.

## Interface
- `B`, 16, instruction width; fixed at 2 bytes.
- `W`, 11, program-memory address width; equals the operand/address width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle strobe that begins a load.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in this cycle.
- `pm_wr_en`  out  1  program-memory write strobe.
- `pm_addr`  out  W  program-memory write address.
- `pm_data`  out  B  program-memory write data.
- `cpu_reset`  out  1  active-high reset to the control unit and datapath.
- `busy`  out  1  load in progress.
- `done`  out  1  load completed successfully; sticky until the next `start`.
- `err`  out  1  load failed; sticky until the next `start`.

## Operation
- States:
  - IDLE: after reset.
  - HI: awaiting the high byte.
  - LO: awaiting the low byte.
  - CHK: awaiting the checksum byte; exists only with the macro.
  - DONE.
  - ERR.
- Reset values: `pm_wr_en`=0, `pm_addr`=0, `pm_data`=0, `cpu_reset`=1, `busy`=0, `done`=0, `err`=0. The state is IDLE and the internal address is 0.
- `start` in IDLE, DONE or ERR:
  - internal address ← 0; `done` and `err` ← 0; `cpu_reset` ← 1; `busy` ← 1;
  - next state is HI.
- `start` in HI, LO or CHK is ignored.
- `rx_valid` in IDLE, DONE or ERR is ignored. A byte arriving in the same cycle as an accepted `start` is also dropped.
- HI + `rx_valid`: latch the byte as the high byte, then go to LO.
- LO + `rx_valid`:
  - `pm_data` ← {hi, rx_data}; `pm_addr` ← internal address; `pm_wr_en` ← 1 for exactly one cycle.
  - If the word is HALT (`pm_data[15:11]`=5'b00000), go to CHK with the macro or DONE without it.
  - Else, if the internal address = 2^W−1, go to ERR (program overflow; the last word is still written).
  - Else, increment the internal address and go to HI.
- DONE: `cpu_reset`=0, `busy`=0, `done`=1.
- ERR: `cpu_reset` stays 1, `busy`=0, `err`=1.
- `pm_addr` and `pm_data` hold their last values between writes.
- An asynchronous reset mid-load returns all outputs to their reset values immediately. A partially written program is abandoned.

## Timing
- Byte-to-write latency: `pm_wr_en` is high in the cycle following the rising edge that samples the low byte.
- The loader accepts `rx_valid` back-to-back, one byte per cycle; no stall is needed because no write state blocks input.
- Minimum load time: 2·N cycles for N words, plus one cycle for the `start` edge.
- Transition into DONE:
  - `done` rises and `cpu_reset` falls on the same edge that raises the HALT word's `pm_wr_en`.
  - With the macro, this happens instead on the edge that samples the checksum byte.
- `busy` is high from the edge after `start` up to the edge entering DONE or ERR.

## Configuration
- Macro: `PROG_LOADER_CHECKSUM_EN`.
- Defined:
  - A running 8-bit XOR covers every instruction byte of the load, including the HALT bytes. It is cleared on `start`.
  - After HALT the loader enters CHK and waits for one further byte.
  - If that byte equals the XOR, go to DONE; otherwise go to ERR.
- Not defined: there is no CHK state and no XOR register; the loader goes from HALT directly to DONE.

## Test plan
- Reset then idle: with `reset`=0, all outputs are at reset values and `cpu_reset`=1. Releasing reset with no `start` leaves the outputs unchanged, even while bytes arrive on `rx_valid`.
- Basic load: `start`, then bytes 18 10 08 01 00 00 on consecutive cycles. Required writes: (0, 16'h1810), (1, 16'h0801), (2, 16'h0000). Then `done`=1 and `cpu_reset`=0.
- Gapped bytes: same load with 3 idle cycles between bytes. Writes are identical; each `pm_wr_en` lasts exactly one cycle.
- Mid-load reset: drop `reset` after byte 08. Outputs return to reset values. A fresh `start` and load writes from address 0 again.
- Restart and overflow: with W=2 forced, write four non-HALT words 0801. The fourth write goes to address 3, then `err`=1 and `cpu_reset` stays 1. A `start` in ERR clears `err` and sets `busy`=1.
- Checksum (macro defined): bytes 18 10 08 01 00 00 then 01 (XOR = 18^10^08^01 = 01) gives `done`=1. Sending 02 instead gives `err`=1 and `cpu_reset`=1.
